// File: rtl/qix_shared_ram_arbiter.sv
// Shared-RAM arbiter: round-robin Data/Video CPU access to a 1-clock sync BRAM plus FIRQ mailbox.
// Latency: grant at edge N, ack high for one cycle after edge N+2; one access per 4 clocks.
// Backpressure: req held until ack; QIX_HS_PORT_EN adds a lowest-priority hiscore loader port.
module qix_shared_ram_arbiter #(
  parameter int            AW             = 11,
  parameter int            DW             = 8,
  parameter logic [AW-1:0] FIRQ_TO_B_ADDR = 11'h7FF,
  parameter logic [AW-1:0] FIRQ_TO_A_ADDR = 11'h7FE
) (
  input  logic          clk_20m,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          firq_a_n,
  output logic          firq_b_n
`ifdef QIX_HS_PORT_EN
  ,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_din,
  output logic [DW-1:0] hs_dout,
  output logic          hs_ack
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
  typedef enum logic [1:0] {GNT_A, GNT_B, GNT_HS} gnt_t;

  state_t        state, state_nxt;
  gnt_t          gnt, gnt_nxt;
  logic          last_b, last_b_nxt;
  logic          sel_a, sel_b, sel_hs;
  logic [AW-1:0] ram_addr_nxt;
  logic          ram_we_nxt;
  logic [DW-1:0] ram_wdata_nxt, a_dout_nxt, b_dout_nxt;
  logic          a_ack_nxt, b_ack_nxt, firq_a_nxt, firq_b_nxt;
  logic          hs_we_i;
  logic [AW-1:0] hs_addr_i;
  logic [DW-1:0] hs_din_i;

`ifdef QIX_HS_PORT_EN
  logic [DW-1:0] hs_dout_nxt;
  logic          hs_ack_nxt;
  assign sel_hs    = hs_req & ~a_req & ~b_req;
  assign hs_we_i   = hs_we;
  assign hs_addr_i = hs_addr;
  assign hs_din_i  = hs_din;
`else
  assign sel_hs    = 1'b0;
  assign hs_we_i   = 1'b0;
  assign hs_addr_i = '0;
  assign hs_din_i  = '0;
`endif

  // last_b set means B won the previous A/B grant, so A wins a tie next.
  assign sel_a = a_req & (~b_req | last_b);
  assign sel_b = b_req & ~sel_a;

  always_ff @(posedge clk_20m) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_a | sel_b | sel_hs) state_nxt = ACCESS;
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt       = gnt;
    last_b_nxt    = last_b;
    ram_addr_nxt  = ram_addr;
    ram_we_nxt    = ram_we;
    ram_wdata_nxt = ram_wdata;
    firq_a_nxt    = firq_a_n;
    firq_b_nxt    = firq_b_n;
    a_dout_nxt    = a_dout;
    b_dout_nxt    = b_dout;
    a_ack_nxt     = 1'b0;
    b_ack_nxt     = 1'b0;
`ifdef QIX_HS_PORT_EN
    hs_dout_nxt   = hs_dout;
    hs_ack_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sel_a) begin
          gnt_nxt       = GNT_A;
          last_b_nxt    = 1'b0;
          ram_addr_nxt  = a_addr;
          ram_we_nxt    = a_we;
          ram_wdata_nxt = a_din;
          if (a_we && a_addr == FIRQ_TO_B_ADDR)  firq_b_nxt = 1'b0;
          if (!a_we && a_addr == FIRQ_TO_A_ADDR) firq_a_nxt = 1'b1;
        end else if (sel_b) begin
          gnt_nxt       = GNT_B;
          last_b_nxt    = 1'b1;
          ram_addr_nxt  = b_addr;
          ram_we_nxt    = b_we;
          ram_wdata_nxt = b_din;
          if (b_we && b_addr == FIRQ_TO_A_ADDR)  firq_a_nxt = 1'b0;
          if (!b_we && b_addr == FIRQ_TO_B_ADDR) firq_b_nxt = 1'b1;
        end else if (sel_hs) begin
          gnt_nxt       = GNT_HS;
          ram_addr_nxt  = hs_addr_i;
          ram_we_nxt    = hs_we_i;
          ram_wdata_nxt = hs_din_i;
        end
      end
      ACCESS: ram_we_nxt = 1'b0;
      CAPTURE: begin
        // BRAM data for the address presented at ACCESS is valid now.
        if (gnt == GNT_A) begin
          a_ack_nxt  = 1'b1;
          a_dout_nxt = ram_rdata;
        end
        if (gnt == GNT_B) begin
          b_ack_nxt  = 1'b1;
          b_dout_nxt = ram_rdata;
        end
`ifdef QIX_HS_PORT_EN
        if (gnt == GNT_HS) begin
          hs_ack_nxt  = 1'b1;
          hs_dout_nxt = ram_rdata;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_20m) begin
    if (!reset_n) begin
      gnt       <= GNT_A;
      last_b    <= 1'b1;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      firq_a_n  <= 1'b1;
      firq_b_n  <= 1'b1;
      a_dout    <= '0;
      b_dout    <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
`ifdef QIX_HS_PORT_EN
      hs_dout   <= '0;
      hs_ack    <= 1'b0;
`endif
    end else begin
      gnt       <= gnt_nxt;
      last_b    <= last_b_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_we    <= ram_we_nxt;
      ram_wdata <= ram_wdata_nxt;
      firq_a_n  <= firq_a_nxt;
      firq_b_n  <= firq_b_nxt;
      a_dout    <= a_dout_nxt;
      b_dout    <= b_dout_nxt;
      a_ack     <= a_ack_nxt;
      b_ack     <= b_ack_nxt;
`ifdef QIX_HS_PORT_EN
      hs_dout   <= hs_dout_nxt;
      hs_ack    <= hs_ack_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_qix_shared_ram_arbiter.sv
// Bench for qix_shared_ram_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model with a shadow memory.
module tb_qix_shared_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk_20m = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_din = '0;
  logic [DW-1:0] a_dout;
  logic          a_ack;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din = '0;
  logic [DW-1:0] b_dout;
  logic          b_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          firq_a_n, firq_b_n;
`ifdef QIX_HS_PORT_EN
  logic          hs_req = 1'b0, hs_we = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [DW-1:0] hs_din = '0;
  logic [DW-1:0] hs_dout;
  logic          hs_ack;
`endif

  always #5 clk_20m = ~clk_20m;

  qix_shared_ram_arbiter dut (
    .clk_20m(clk_20m), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_ack(b_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .firq_a_n(firq_a_n), .firq_b_n(firq_b_n)
`ifdef QIX_HS_PORT_EN
    , .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_din(hs_din),
    .hs_dout(hs_dout), .hs_ack(hs_ack)
`endif
  );

  // Single-port BRAM, read-first.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk_20m) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one access occupies 4 edges starting at its grant.
  logic [DW-1:0] shadow [2**AW];
  int            ph = 0;
  int            mg = 0;
  int            m_last = 1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          exp_ack [3] = '{0, 0, 0};
  logic [DW-1:0] exp_dout [3] = '{0, 0, 0};
  bit            known [3] = '{1, 1, 1};
  logic          exp_we = 1'b0, exp_fa = 1'b1, exp_fb = 1'b1;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          r [3];
  logic          w [3];
  logic [AW-1:0] ad [3];
  logic [DW-1:0] dn [3];

  always @(posedge clk_20m) begin
    r[0] = a_req; w[0] = a_we; ad[0] = a_addr; dn[0] = a_din;
    r[1] = b_req; w[1] = b_we; ad[1] = b_addr; dn[1] = b_din;
`ifdef QIX_HS_PORT_EN
    r[2] = hs_req; w[2] = hs_we; ad[2] = hs_addr; dn[2] = hs_din;
`else
    r[2] = 1'b0; w[2] = 1'b0; ad[2] = '0; dn[2] = '0;
`endif
    for (int i = 0; i < 3; i++) exp_ack[i] = 1'b0;
    if (!reset_n) begin
      // The BRAM still commits a write whose enable is high at the reset edge.
      if (ph == 1 && m_we) shadow[m_addr] = exp_wdata;
      ph = 0; m_last = 1; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_fa = 1; exp_fb = 1;
      for (int i = 0; i < 3; i++) begin exp_dout[i] = '0; known[i] = 1; end
    end else begin
      case (ph)
        0: begin
          mg = -1;
          if (r[0] && r[1]) mg = (m_last == 0) ? 1 : 0;
          else if (r[0])    mg = 0;
          else if (r[1])    mg = 1;
          else if (r[2])    mg = 2;
          if (mg >= 0) begin
            m_we = w[mg]; m_addr = ad[mg];
            exp_we = w[mg]; exp_addr = ad[mg]; exp_wdata = dn[mg];
            if (mg < 2) m_last = mg;
            if (mg == 0 &&  m_we && m_addr == 11'h7FF) exp_fb = 0;
            if (mg == 1 && !m_we && m_addr == 11'h7FF) exp_fb = 1;
            if (mg == 1 &&  m_we && m_addr == 11'h7FE) exp_fa = 0;
            if (mg == 0 && !m_we && m_addr == 11'h7FE) exp_fa = 1;
            ph = 1;
          end
        end
        1: begin
          if (m_we) shadow[m_addr] = exp_wdata;
          exp_we = 0;
          ph = 2;
        end
        2: begin
          exp_ack[mg] = 1;
          if (!m_we) begin exp_dout[mg] = shadow[m_addr]; known[mg] = 1; end
          else known[mg] = 0;
          ph = 3;
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk_20m) begin
    if (chk_en) begin
      check("a_ack", a_ack, exp_ack[0]);
      check("b_ack", b_ack, exp_ack[1]);
      if (known[0]) check("a_dout", a_dout, exp_dout[0]);
      if (known[1]) check("b_dout", b_dout, exp_dout[1]);
      check("ram_we", ram_we, exp_we);
      check("ram_addr", ram_addr, exp_addr);
      check("ram_wdata", ram_wdata, exp_wdata);
      check("firq_a_n", firq_a_n, exp_fa);
      check("firq_b_n", firq_b_n, exp_fb);
`ifdef QIX_HS_PORT_EN
      check("hs_ack", hs_ack, exp_ack[2]);
      if (known[2]) check("hs_dout", hs_dout, exp_dout[2]);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_20m);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 11'h7FF;
      1:       return 11'h7FE;
      2:       return 11'($urandom_range(0, 15));
      default: return 11'($urandom);
    endcase
  endfunction

  int ack_cyc [$];
  string ack_who [$];
  int hs_seen, a_done;
  bit got;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin mem[i] = '0; shadow[i] = '0; end
    tick(3);
    chk_en = 1;
    check("rst a_ack", a_ack, 0);
    check("rst ram_we", ram_we, 0);
    check("rst firq_b_n", firq_b_n, 1);
    check("rst a_dout", a_dout, 0);
    reset_n = 1;

    // A write 5A to 010
    a_req = 1; a_we = 1; a_addr = 11'h010; a_din = 8'h5A;
    tick(1);
    check("wr ram_we N", ram_we, 1);
    check("wr ram_addr N", ram_addr, 11'h010);
    tick(1);
    check("wr ram_we N+1", ram_we, 0);
    check("wr a_ack early", a_ack, 0);
    tick(1);
    check("wr a_ack", a_ack, 1);
    a_req = 0;
    tick(1);
    check("wr a_ack drop", a_ack, 0);

    // A read back of 010
    a_req = 1; a_we = 0; a_addr = 11'h010;
    tick(3);
    check("rd a_ack", a_ack, 1);
    check("rd a_dout", a_dout, 8'h5A);
    check("rd b_ack", b_ack, 0);
    a_req = 0;
    tick(1);
    check("rd a_ack drop", a_ack, 0);

    // Round-robin with both held from reset
    reset_n = 0;
    tick(1);
    reset_n = 1;
    a_req = 1; a_we = 0; a_addr = 11'h001;
    b_req = 1; b_we = 0; b_addr = 11'h002;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      if (a_ack) begin ack_cyc.push_back(i); ack_who.push_back("A"); end
      if (b_ack) begin ack_cyc.push_back(i); ack_who.push_back("B"); end
    end
    a_req = 0; b_req = 0;
    check("rr count", ack_cyc.size(), 4);
    if (ack_cyc.size() == 4) begin
      check("rr order0", (ack_who[0] == "A"), 1);
      check("rr order1", (ack_who[1] == "B"), 1);
      check("rr order2", (ack_who[2] == "A"), 1);
      check("rr order3", (ack_who[3] == "B"), 1);
      check("rr first cyc", ack_cyc[0], 3);
      check("rr spacing", ack_cyc[3] - ack_cyc[0], 12);
    end
    tick(1);

    // Mailbox A->B
    a_req = 1; a_we = 1; a_addr = 11'h7FF; a_din = 8'hAA;
    tick(1);
    check("mb firq_b set", firq_b_n, 0);
    check("mb firq_a idle", firq_a_n, 1);
    tick(2);
    a_req = 0;
    tick(1);
    b_req = 1; b_we = 0; b_addr = 11'h7FF;
    tick(1);
    check("mb firq_b clr", firq_b_n, 1);
    check("mb firq_a idle2", firq_a_n, 1);
    tick(2);
    check("mb b_dout", b_dout, 8'hAA);
    b_req = 0;
    tick(1);

    // Reset during ACCESS abandons the access
    a_req = 1; a_we = 1; a_addr = 11'h020; a_din = 8'h33;
    tick(1);
    reset_n = 0; a_req = 0;
    tick(1);
    check("ar ram_we", ram_we, 0);
    reset_n = 1;
    got = 0;
    for (int i = 0; i < 4; i++) begin tick(1); if (a_ack) got = 1; end
    check("ar no ack", got, 0);
    a_req = 1; a_we = 0; a_addr = 11'h010;
    tick(3);
    check("ar reread ack", a_ack, 1);
    check("ar reread dout", a_dout, 8'h5A);
    a_req = 0;
    tick(1);

`ifdef QIX_HS_PORT_EN
    // hs starved while A keeps requesting; hs write to 7FF has no FIRQ effect
    hs_req = 1; hs_we = 1; hs_addr = 11'h7FF; hs_din = 8'h11;
    a_req = 1; a_we = 0; a_addr = 11'h010;
    hs_seen = 0; a_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (hs_ack) hs_seen++;
      if (a_ack) begin a_req = 0; a_done++; end
      else if (!a_req && a_done < 3) a_req = 1;
    end
    check("hs starved", hs_seen, 0);
    check("hs a_done", a_done, 3);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin tick(1); if (hs_ack) got = 1; end
    check("hs ack seen", got, 1);
    check("hs firq_b_n", firq_b_n, 1);
    hs_req = 0;
    tick(1);
`endif

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_20m);
      #1;
      reset_n = ($urandom_range(0, 399) != 0);
      if (a_req && a_ack) a_req = 0;
      else if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1; a_we = 1'($urandom_range(0, 1)); a_addr = pick_addr(); a_din = 8'($urandom);
      end
      if (b_req && b_ack) b_req = 0;
      else if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1; b_we = 1'($urandom_range(0, 1)); b_addr = pick_addr(); b_din = 8'($urandom);
      end
`ifdef QIX_HS_PORT_EN
      if (hs_req && hs_ack) hs_req = 0;
      else if (!hs_req && $urandom_range(0, 3) == 0) begin
        hs_req = 1; hs_we = 1'($urandom_range(0, 1)); hs_addr = pick_addr(); hs_din = 8'($urandom);
      end
`endif
    end
    reset_n = 1; a_req = 0; b_req = 0;
`ifdef QIX_HS_PORT_EN
    hs_req = 0;
`endif
    tick(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
